// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the packet readout scheduler.
package pkt_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } sched_state_e;

    // Top two bits of every header word.
    localparam logic [1:0] HDR_PREFIX = 2'b10;

    // Number of paths in the two readout configurations.
    localparam int PATHS_48 = 48;
    localparam int PATHS_96 = 96;

    // Data words per packet: 64 << code (64/128/256/512).
    function automatic logic [9:0] data_len(input logic [1:0] code);
        return 10'd64 << code;
    endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Down-counter timing the idle gap between packets. Loading L-1 gives an
// L-cycle gap: done is high while the count sits at zero.
module pkt_gap_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic        done
);

    logic [15:0] cnt_q, cnt_d;

    // Load on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 16'd0);

endmodule

// File: rtl/pkt_sched.sv
// Packet readout scheduler: streams each path as a header word plus N data
// words from capture memory onto the pad bus, with idle gaps in between.
// Memory reads are issued one cycle ahead of the state that consumes them:
// the read of word 0 goes out in the cycle that decides to send a header,
// so data word 0 lands on the bus right after the header.
module pkt_sched
    import pkt_sched_pkg::*;
#(
    parameter int DW = 18,
    parameter int PW = 7,
    parameter int AW = 9
) (
    input  logic          pktctrl_clk,
    input  logic          pktctrl_rstn,
    input  logic          rf_capture_start,
    input  logic          rf_capture_mode,
    input  logic          rf_capture_again,
    input  logic          rf_96path_en,
    input  logic [1:0]    rf_pkt_data_length,
    input  logic [15:0]   rf_pkt_idle_length,
    input  logic          DATA_RD_EN,
    output logic          mem_rd_en,
    output logic [PW-1:0] mem_rd_path,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic [DW-1:0] ADC_DATA,
    output logic          ADC_DATA_VALID,
    output logic          sched_busy,
    output logic          sched_done
);

    sched_state_e  state_q, state_d;
    logic [PW-1:0] path_q, path_d;
    logic [AW-1:0] word_q, word_d;
    logic          p96_q, p96_d;
    logic [1:0]    len_q, len_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          start_q, again_q;

    logic          rd_en;
    logic [PW-1:0] rd_path;
    logic [AW-1:0] rd_addr;
    logic          gap_load, gap_done;
    logic          start_edge, again_edge;
    logic          last_word, at_boundary;
    logic [AW-1:0] last_idx;
    logic [AW:0]   word_p2;
    logic [PW-1:0] last_path, nxt_path;
    logic [DW-1:0] hdr_cur, hdr_nxt;

    assign start_edge = rf_capture_start & ~start_q;
    assign again_edge = rf_capture_again & ~again_q;
    assign last_idx   = AW'(data_len(len_q) - 10'd1);
    assign last_word  = (word_q == last_idx);
    assign word_p2    = {1'b0, word_q} + (AW+1)'(2);
    assign last_path  = p96_q ? PW'(PATHS_96 - 1) : PW'(PATHS_48 - 1);
    assign nxt_path   = (path_q == last_path) ? '0 : path_q + PW'(1);
    assign hdr_cur    = {HDR_PREFIX, {(DW-2-PW){1'b0}}, path_q};
    assign hdr_nxt    = {HDR_PREFIX, {(DW-2-PW){1'b0}}, nxt_path};

    // Packet boundary: last idle cycle, or the last data word when there is no gap.
    assign at_boundary = ((state_q == ST_DATA) && last_word && (rf_pkt_idle_length == 16'd0))
                       || ((state_q == ST_GAP) && gap_done);

    pkt_gap_timer u_gap_timer (
        .clk      (pktctrl_clk),
        .rst_n    (pktctrl_rstn),
        .load     (gap_load),
        .load_val (rf_pkt_idle_length - 16'd1),
        .done     (gap_done)
    );

    // Next-state, memory read and bus word selection.
    always_comb begin
        state_d  = state_q;
        path_d   = path_q;
        word_d   = word_q;
        p96_d    = p96_q;
        len_d    = len_q;
        mode_d   = mode_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        rd_en    = 1'b0;
        rd_path  = path_q;
        rd_addr  = '0;
        gap_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_ARM;
                    path_d  = '0;
                    p96_d   = rf_96path_en;
                    len_d   = rf_pkt_data_length;
                    mode_d  = rf_capture_mode;
                end
            end
            ST_ARM: begin
                if (!rf_capture_start) begin
                    state_d = ST_IDLE;
                end else if (DATA_RD_EN) begin
                    rd_en   = 1'b1;
                    data_d  = hdr_cur;
                    valid_d = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                rd_en   = 1'b1;
                rd_addr = AW'(1);
                data_d  = mem_rd_data;
                valid_d = 1'b1;
                word_d  = '0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (word_p2 <= {1'b0, last_idx}) begin
                    rd_en   = 1'b1;
                    rd_addr = word_p2[AW-1:0];
                end
                if (!last_word) begin
                    data_d  = mem_rd_data;
                    valid_d = 1'b1;
                    word_d  = word_q + AW'(1);
                end else if (rf_pkt_idle_length != 16'd0) begin
                    gap_load = 1'b1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_GAP;
            end
            ST_DONE: begin
                if (!rf_capture_start) begin
                    state_d = ST_IDLE;
                end else if (again_edge) begin
                    state_d = ST_ARM;
                    path_d  = '0;
                    p96_d   = rf_96path_en;
                    len_d   = rf_pkt_data_length;
                    mode_d  = rf_capture_mode;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (at_boundary) begin
            if (!rf_capture_start) begin
                state_d = ST_IDLE;
            end else if ((path_q == last_path) && !mode_q) begin
                state_d = ST_DONE;
            end else begin
                path_d = nxt_path;
                if (DATA_RD_EN) begin
                    rd_en   = 1'b1;
                    rd_path = nxt_path;
                    data_d  = hdr_nxt;
                    valid_d = 1'b1;
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_ARM;
                end
            end
        end

        busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d = (state_d == ST_DONE);
    end

    // State, run configuration, edge detectors and registered bus outputs.
    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            state_q <= ST_IDLE;
            path_q  <= '0;
            word_q  <= '0;
            p96_q   <= 1'b0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            again_q <= 1'b0;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            word_q  <= word_d;
            p96_q   <= p96_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= rf_capture_start;
            again_q <= rf_capture_again;
        end
    end

    assign mem_rd_en      = rd_en;
    assign mem_rd_path    = rd_path;
    assign mem_rd_addr    = rd_addr;
    assign ADC_DATA       = data_q;
    assign ADC_DATA_VALID = valid_q;
    assign sched_busy     = busy_q;
    assign sched_done     = done_q;

endmodule

// File: doc/pkt_sched.md
# pkt_sched

Packet readout scheduler inside the packet-control domain. It sequences captured ADC sample memory out onto the 18-bit pad bus. Packets go out path by path (48 or 96 paths), each as one header word plus N data words, with a programmable idle gap between packets. Flow is gated by the external read enable. The block sits between the capture memory read port and the `ADC_DATA`/`ADC_DATA_VALID` pad outputs, and is configured by the regfile `rf_*` fields.

## Interface
Parameters:
- `DW`, 18: bus / memory data width
- `PW`, 7: path index width
- `AW`, 9: memory word address width

Ports:
- `pktctrl_clk`  in  1  packet-control clock; sole clock of the block
- `pktctrl_rstn`  in  1  asynchronous active-low reset
- `rf_capture_start`  in  1  level; rising edge in IDLE starts a run; low requests stop at the next packet boundary
- `rf_capture_mode`  in  1  0 = single pass over all paths, 1 = continuous wrap
- `rf_capture_again`  in  1  rising edge in DONE restarts from path 0
- `rf_96path_en`  in  1  0 = 48 paths (0..47), 1 = 96 paths (0..95)
- `rf_pkt_data_length`  in  2  data words per packet N = 64 << value (64/128/256/512)
- `rf_pkt_idle_length`  in  16  idle cycles between packets
- `DATA_RD_EN`  in  1  downstream ready; sampled only at packet boundaries
- `mem_rd_en`  out  1  memory read strobe
- `mem_rd_path`  out  PW  path being read
- `mem_rd_addr`  out  AW  word address within path
- `mem_rd_data`  in  DW  read data; valid exactly 1 cycle after `mem_rd_en`
- `ADC_DATA`  out  DW  registered bus word
- `ADC_DATA_VALID`  out  1  registered word qualifier
- `sched_busy`  out  1  high in every state except IDLE and DONE
- `sched_done`  out  1  high in DONE

## Operation
- States:
  - IDLE: wait for `rf_capture_start` rising edge (edge detector registered, reset 0).
  - ARM: wait for `DATA_RD_EN` = 1, then go to HDR.
  - HDR: one cycle; output header word {2'b10, 9'd0, path[6:0]} with VALID = 1; issue read of address 0.
  - DATA: N cycles. Output data words in address order with VALID continuously high. Issue read for address k+1 while word k-1 is on the bus; no read beyond N-1.
  - GAP: count `rf_pkt_idle_length` cycles with VALID = 0, then:
    - if `rf_capture_start` = 0 → IDLE;
    - else if last path and mode = 0 → DONE;
    - else advance the path (wrapping last→0 in mode 1) and go to ARM.
  - DONE: hold VALID = 0; `rf_capture_again` rising edge → ARM at path 0; `rf_capture_start` = 0 → IDLE.
- Idle length 0: GAP lasts 0 cycles; the next header can directly follow the last data word if `DATA_RD_EN` = 1.
- Packets are never truncated. `DATA_RD_EN` or `rf_capture_start` dropping mid-packet only takes effect at GAP/ARM.
- `rf_96path_en`, `rf_pkt_data_length` and mode are latched at ARM-from-IDLE/DONE; changes during a run are ignored until the next start.
- Last path = 47 or 95 per the latched `rf_96path_en`.

## Timing
- Reset values:
  - `ADC_DATA` = 0, `ADC_DATA_VALID` = 0, `mem_rd_en` = 0, `mem_rd_path` = 0, `mem_rd_addr` = 0;
  - `sched_busy` = 0, `sched_done` = 0; state IDLE, path 0.
- Start edge sampled at cycle T → ARM at T+1. With `DATA_RD_EN` high, the header is on the bus at T+2.
- Data word for address k appears on `ADC_DATA` exactly 2 cycles after its `mem_rd_en`. The header immediately precedes data word 0, and the packet is 1+N contiguous valid cycles.
- Between packets, exactly `rf_pkt_idle_length` cycles of VALID = 0 when `DATA_RD_EN` stays high. Each extra cycle of `DATA_RD_EN` low adds one idle cycle.
- Reset asserted mid-packet: all outputs go to their reset values immediately (async); no partial state survives.
- Simultaneous start low and again edge in DONE: IDLE wins.

## Structure
- Shared package `pkt_sched_pkg`:
  - state enum;
  - header prefix constant 2'b10;
  - path counts 48/96;
  - length decode function (2-bit → N).
- Sub-module `pkt_gap_timer`: 16-bit down-counter with load/done, used for GAP.

## Test plan
- Length 0 (N = 64), idle 4, 48 paths, mode 0, start edge → 48 packets of 65 valid words, headers 0x20000..0x2002F, 4-cycle gaps, then `sched_done` = 1.
- 96 paths, mode 1, length 3 → after path 95 the next header is path 0; `sched_done` never asserts.
- Drop `DATA_RD_EN` mid packet 5 for 20 cycles → packet 5 completes intact; gap extends to idle + 20 remaining-low cycles; packet 6 is correct.
- Idle 0, length 0 → header of path n+1 immediately follows the last data word of path n; no VALID bubble.
- In DONE, `rf_capture_again` edge → header of path 0 two cycles later. Separately, reset mid-DATA → all outputs 0, state IDLE; a fresh start edge restarts at path 0.
